// File: rtl/timer_pkg.sv
// Shared types and constants for the MM:SS BCD countdown timer.
package timer_pkg;

    // Controller states; running/done outputs are decoded from these.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READY  = 3'd1,
        ST_RUN    = 3'd2,
        ST_PAUSED = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // One packed BCD digit.
    typedef logic [3:0] bcd_t;

    localparam bcd_t        SEC_TENS_MAX = 4'd5;
    localparam bcd_t        DIGIT_MAX    = 4'd9;
    localparam logic [15:0] ZERO_TIME    = 16'h0000;

    // A preset is usable only if every digit is within its own wrap range.
    // Minute tens is capped like second tens, so the longest time is 59:59.
    function automatic logic preset_valid(input logic [15:0] p);
        return (p[15:12] <= SEC_TENS_MAX) && (p[11:8] <= DIGIT_MAX) &&
               (p[7:4]   <= SEC_TENS_MAX) && (p[3:0]  <= DIGIT_MAX);
    endfunction

endpackage

// File: rtl/timer_countdown_if.sv
// Strobe/status bundle of the countdown timer.
// Build option TIMER_BEEP_EN adds the beep status line.
interface timer_countdown_if;

    logic [15:0] preset;
    logic        load;
    logic        start;
    logic        pause;
    logic [15:0] count;
    logic        running;
    logic        done;
    logic        load_err;
`ifdef TIMER_BEEP_EN
    logic        beep;

    modport master (output preset, load, start, pause,
                    input  count, running, done, load_err, beep);
    modport slave  (input  preset, load, start, pause,
                    output count, running, done, load_err, beep);
`else
    modport master (output preset, load, start, pause,
                    input  count, running, done, load_err);
    modport slave  (input  preset, load, start, pause,
                    output count, running, done, load_err);
`endif

endinterface

// File: rtl/timer_countdown_bcd_digit_down.sv
// Single BCD digit down counter. Wraps from 0 to MAX and raises borrow
// combinationally in the cycle it wraps, so digits chain into MM:SS.
module bcd_digit_down
    import timer_pkg::*;
#(
    parameter bcd_t MAX = DIGIT_MAX
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ld,
    input  bcd_t ld_val,
    input  logic dec,
    output bcd_t digit,
    output logic borrow
);

    bcd_t digit_q;
    bcd_t digit_d;

    // Load has precedence over decrement; decrement from zero wraps to MAX.
    always_comb begin
        digit_d = digit_q;
        if (ld) begin
            digit_d = ld_val;
        end else if (dec) begin
            digit_d = (digit_q == 4'd0) ? MAX : digit_q - 4'd1;
        end
    end

    // Digit register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_q <= 4'd0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit  = digit_q;
    assign borrow = dec && (digit_q == 4'd0);

endmodule

// File: rtl/timer_countdown.sv
// MM:SS BCD countdown timer with load/start/pause strobes.
// Build option TIMER_BEEP_EN adds a 0.5 Hz beep output while expired.
module timer_countdown
    import timer_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic               clk,
    input  logic               rst_n,
    timer_countdown_if.slave   bus
);

    localparam int          DIV_W       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [15:0] LAST_SECOND = 16'h0001;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             running_q, running_d;
    logic             done_q, done_d;
    logic             load_err_q, load_err_d;

    logic             load_ok, load_bad;
    logic             div_wrap, div_adv, run_tick;

    bcd_t             sec_ones, sec_tens, min_ones, min_tens;
    logic             b_sec_ones, b_sec_tens, b_min_ones, b_min_tens;
    logic [15:0]      count_w;

    assign count_w = {min_tens, min_ones, sec_tens, sec_ones};

    // Strobe qualification and tick generation. A tick is withheld on a
    // load or pause cycle and whenever the count is already zero.
    always_comb begin
        load_ok  = bus.load && preset_valid(bus.preset);
        load_bad = bus.load && !preset_valid(bus.preset);
        div_wrap = (div_q == DIV_LAST);
        div_adv  = !bus.load &&
                   (((state_q == ST_RUN) && !bus.pause) || (state_q == ST_DONE));
        run_tick = (state_q == ST_RUN) && !bus.load && !bus.pause && div_wrap &&
                   (count_w != ZERO_TIME);
    end

    // Seconds borrow chain: ss ones -> ss tens -> mm ones -> mm tens.
    bcd_digit_down #(.MAX(DIGIT_MAX)) u_sec_ones (
        .clk(clk), .rst_n(rst_n), .ld(load_ok), .ld_val(bus.preset[3:0]),
        .dec(run_tick), .digit(sec_ones), .borrow(b_sec_ones)
    );
    bcd_digit_down #(.MAX(SEC_TENS_MAX)) u_sec_tens (
        .clk(clk), .rst_n(rst_n), .ld(load_ok), .ld_val(bus.preset[7:4]),
        .dec(b_sec_ones), .digit(sec_tens), .borrow(b_sec_tens)
    );
    bcd_digit_down #(.MAX(DIGIT_MAX)) u_min_ones (
        .clk(clk), .rst_n(rst_n), .ld(load_ok), .ld_val(bus.preset[11:8]),
        .dec(b_sec_tens), .digit(min_ones), .borrow(b_min_ones)
    );
    bcd_digit_down #(.MAX(SEC_TENS_MAX)) u_min_tens (
        .clk(clk), .rst_n(rst_n), .ld(load_ok), .ld_val(bus.preset[15:12]),
        .dec(b_min_ones), .digit(min_tens), .borrow(b_min_tens)
    );

    // Tick divider: cleared by a good load, frozen while paused, free-running
    // in DONE so expiry-time features have a one-second time base.
    always_comb begin
        div_d = div_q;
        if (load_ok) begin
            div_d = '0;
        end else if (div_adv) begin
            div_d = div_wrap ? '0 : div_q + 1'b1;
        end
    end

    // Next state with strobe priority load > pause > start. A borrow out of
    // the minute tens would mean underflow, so it is treated as expiry too.
    always_comb begin
        state_d = state_q;
        if (bus.load) begin
            if (load_ok) begin
                state_d = (bus.preset == ZERO_TIME) ? ST_IDLE : ST_READY;
            end
        end else if (bus.pause && (state_q == ST_RUN)) begin
            state_d = ST_PAUSED;
        end else if (bus.start && ((state_q == ST_READY) || (state_q == ST_PAUSED))) begin
            state_d = ST_RUN;
        end else if (run_tick && ((count_w == LAST_SECOND) || b_min_tens)) begin
            state_d = ST_DONE;
        end
    end

    // Status outputs are decoded from the next state so they register together.
    always_comb begin
        running_d  = (state_d == ST_RUN);
        done_d     = (state_d == ST_DONE);
        load_err_d = load_bad;
    end

    // Control and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            div_q      <= '0;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            running_q  <= running_d;
            done_q     <= done_d;
            load_err_q <= load_err_d;
        end
    end

    assign bus.count    = count_w;
    assign bus.running  = running_q;
    assign bus.done     = done_q;
    assign bus.load_err = load_err_q;

`ifdef TIMER_BEEP_EN
    logic beep_q, beep_d;

    // Beep starts high on entry to DONE and toggles every second while there.
    always_comb begin
        beep_d = 1'b0;
        if (state_d == ST_DONE) begin
            if (state_q != ST_DONE) begin
                beep_d = 1'b1;
            end else if (div_wrap && !bus.load) begin
                beep_d = ~beep_q;
            end else begin
                beep_d = beep_q;
            end
        end
    end

    // Beep register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beep_q <= 1'b0;
        end else begin
            beep_q <= beep_d;
        end
    end

    assign bus.beep = beep_q;
`endif

endmodule

// File: tb/tb_timer_countdown.sv
// Self-checking bench for timer_countdown (default build, no beep).
module tb_timer_countdown;

    localparam int TICK_DIV = 4;
    localparam int M_IDLE = 0, M_READY = 1, M_RUN = 2, M_PAUSED = 3, M_DONE = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int n_err = 0;
    int n_checks = 0;

    // Reference model: remaining time as a plain number of seconds.
    int m_st;
    int m_secs;
    int m_phase;
    bit m_err;

    timer_countdown_if bus();

    timer_countdown #(.TICK_DIV(TICK_DIV)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic bit is_valid(input int p);
        return ((p >> 12) & 15) <= 5 && ((p >> 8) & 15) <= 9 &&
               ((p >> 4) & 15) <= 5 && (p & 15) <= 9;
    endfunction

    function automatic int secs_of(input int p);
        int mins, secs;
        mins = ((p >> 12) & 15) * 10 + ((p >> 8) & 15);
        secs = ((p >> 4) & 15) * 10 + (p & 15);
        return mins * 60 + secs;
    endfunction

    function automatic logic [15:0] bcd_of(input int total);
        int m, s;
        m = total / 60;
        s = total % 60;
        return 16'(((m / 10) << 12) | ((m % 10) << 8) | ((s / 10) << 4) | (s % 10));
    endfunction

    task automatic model_reset();
        m_st = M_IDLE;
        m_secs = 0;
        m_phase = 0;
        m_err = 1'b0;
    endtask

    task automatic model_edge(input logic ld, input logic st, input logic ps,
                              input logic [15:0] pre);
        m_err = 1'b0;
        if (ld) begin
            if (is_valid(int'(pre))) begin
                m_secs = secs_of(int'(pre));
                m_phase = 0;
                m_st = (m_secs == 0) ? M_IDLE : M_READY;
            end else begin
                m_err = 1'b1;
            end
        end else if (ps && m_st == M_RUN) begin
            m_st = M_PAUSED;
        end else if (st && (m_st == M_READY || m_st == M_PAUSED)) begin
            m_st = M_RUN;
        end else if (m_st == M_RUN) begin
            m_phase++;
            if (m_phase == TICK_DIV) begin
                m_phase = 0;
                m_secs--;
                if (m_secs == 0) m_st = M_DONE;
            end
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check($sformatf("%s.count", tag), bus.count, bcd_of(m_secs));
        check($sformatf("%s.running", tag), 16'(bus.running), 16'(m_st == M_RUN));
        check($sformatf("%s.done", tag), 16'(bus.done), 16'(m_st == M_DONE));
        check($sformatf("%s.load_err", tag), 16'(bus.load_err), 16'(m_err));
    endtask

    // Drive strobes for one clock, update the model at the edge, check at negedge.
    task automatic step(input logic ld, input logic st, input logic ps,
                        input logic [15:0] pre, input string tag);
        bus.load = ld;
        bus.start = st;
        bus.pause = ps;
        bus.preset = pre;
        @(posedge clk);
        model_edge(ld, st, ps, pre);
        @(negedge clk);
        check_model(tag);
        bus.load = 1'b0;
        bus.start = 1'b0;
        bus.pause = 1'b0;
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 16'h0000, tag);
    endtask

    initial begin
        bus.load = 1'b0;
        bus.start = 1'b0;
        bus.pause = 1'b0;
        bus.preset = 16'h0000;
        model_reset();

        // Reset state.
        #1;
        check("rst.count", bus.count, 16'h0000);
        check("rst.running", 16'(bus.running), 16'h0000);
        check("rst.done", 16'(bus.done), 16'h0000);
        check("rst.load_err", 16'(bus.load_err), 16'h0000);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1, "rst_rel");

        // Load and count with BCD borrow across the minute.
        step(1'b1, 1'b0, 1'b0, 16'h0103, "cnt_load");
        step(1'b0, 1'b1, 1'b0, 16'h0000, "cnt_start");
        idle(3, "cnt_wait");
        check("cnt.before_tick", bus.count, 16'h0103);
        idle(1, "cnt_t1");
        check("cnt.t1", bus.count, 16'h0102);
        idle(4, "cnt_t2");
        check("cnt.t2", bus.count, 16'h0101);
        idle(4, "cnt_t3");
        check("cnt.t3", bus.count, 16'h0100);
        idle(4, "cnt_t4");
        check("cnt.t4", bus.count, 16'h0059);

        // Expiry, then a start in DONE must be ignored.
        step(1'b1, 1'b0, 1'b0, 16'h0001, "exp_load");
        step(1'b0, 1'b1, 1'b0, 16'h0000, "exp_start");
        idle(4, "exp_wait");
        check("exp.count", bus.count, 16'h0000);
        check("exp.done", 16'(bus.done), 16'h0001);
        check("exp.running", 16'(bus.running), 16'h0000);
        step(1'b0, 1'b1, 1'b0, 16'h0000, "exp_restart");
        idle(5, "exp_hold");
        check("exp.hold_done", 16'(bus.done), 16'h0001);

        // Pause two cycles into a period, hold, resume.
        step(1'b1, 1'b0, 1'b0, 16'h0010, "pau_load");
        step(1'b0, 1'b1, 1'b0, 16'h0000, "pau_start");
        idle(2, "pau_pre");
        step(1'b0, 1'b0, 1'b1, 16'h0000, "pau_pause");
        idle(10, "pau_hold");
        check("pau.held_count", bus.count, 16'h0010);
        step(1'b0, 1'b1, 1'b0, 16'h0000, "pau_resume");
        idle(1, "pau_r1");
        check("pau.r1_count", bus.count, 16'h0010);
        idle(1, "pau_r2");
        check("pau.r2_count", bus.count, 16'h0009);

        // Invalid loads leave count and state alone.
        step(1'b1, 1'b0, 1'b0, 16'h0123, "inv_good");
        step(1'b1, 1'b0, 1'b0, 16'h0A00, "inv_0a00");
        check("inv.err_0a00", 16'(bus.load_err), 16'h0001);
        check("inv.count_0a00", bus.count, 16'h0123);
        idle(1, "inv_gap");
        check("inv.err_clear", 16'(bus.load_err), 16'h0000);
        step(1'b1, 1'b0, 1'b0, 16'h0060, "inv_0060");
        check("inv.err_0060", 16'(bus.load_err), 16'h0001);
        step(1'b0, 1'b1, 1'b0, 16'h0000, "inv_start");
        check("inv.still_ready", 16'(bus.running), 16'h0001);

        // Load and start together during RUN: load wins.
        idle(2, "sim_run");
        step(1'b1, 1'b1, 1'b0, 16'h0200, "sim_both");
        check("sim.count", bus.count, 16'h0200);
        check("sim.running", 16'(bus.running), 16'h0000);
        step(1'b0, 1'b1, 1'b0, 16'h0000, "sim_ready_start");

        // Asynchronous reset in the middle of RUN.
        step(1'b1, 1'b0, 1'b0, 16'h0530, "ar_load");
        step(1'b0, 1'b1, 1'b0, 16'h0000, "ar_start");
        idle(5, "ar_run");
        #2;
        rst_n = 1'b0;
        #1;
        check("ar.count", bus.count, 16'h0000);
        check("ar.running", 16'(bus.running), 16'h0000);
        check("ar.done", 16'(bus.done), 16'h0000);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b1, 1'b0, 16'h0000, "ar_idle_start");

        // Randomized strobes and presets against the model.
        for (int i = 0; i < 600; i++) begin
            logic ld, st, ps;
            logic [15:0] pre;
            int r;
            ld = ($urandom_range(0, 19) == 0);
            st = ($urandom_range(0, 5) == 0);
            ps = ($urandom_range(0, 11) == 0);
            r = $urandom_range(0, 9);
            if (r < 2) begin
                pre = 16'($urandom);
            end else if (r < 6) begin
                pre = 16'($urandom_range(0, 3));
            end else begin
                pre = bcd_of($urandom_range(0, 3599));
            end
            step(ld, st, ps, pre, "rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
